// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: processes DATA_WIDTH-bit operands CHUNK_WIDTH bits per clock
// behind valid/ready handshakes, producing result plus carry/overflow/zero flags.
module chunked_add_sub #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] a_sh_q;
  logic [DATA_WIDTH-1:0] b_sh_q;
  logic                  carry_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [CHUNK_WIDTH:0]   chunk_sum;
  logic                   msb_cin;
  logic                   last_chunk;
  logic [DATA_WIDTH-1:0]  res_next;

  function automatic logic [CHUNK_WIDTH:0] add_chunk(
    input logic [CHUNK_WIDTH-1:0] x,
    input logic [CHUNK_WIDTH-1:0] y,
    input logic                   cin
  );
    add_chunk = {1'b0, x} + {1'b0, y} + {{CHUNK_WIDTH{1'b0}}, cin};
  endfunction

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign chunk_sum  = add_chunk(a_sh_q[CHUNK_WIDTH-1:0], b_sh_q[CHUNK_WIDTH-1:0], carry_q);
  // Carry into the top bit of the slice recovered from the sum bit: s = a ^ b ^ cin.
  assign msb_cin    = a_sh_q[CHUNK_WIDTH-1] ^ b_sh_q[CHUNK_WIDTH-1] ^ chunk_sum[CHUNK_WIDTH-1];
  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  generate
    if (CHUNK_WIDTH == DATA_WIDTH) begin : g_single
      assign res_next = chunk_sum[CHUNK_WIDTH-1:0];
    end else begin : g_multi
      assign res_next = {chunk_sum[CHUNK_WIDTH-1:0], result[DATA_WIDTH-1:CHUNK_WIDTH]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          a_sh_q  <= a_sh_q >> CHUNK_WIDTH;
          b_sh_q  <= b_sh_q >> CHUNK_WIDTH;
          carry_q <= chunk_sum[CHUNK_WIDTH];
          result  <= res_next;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_chunk) begin
            carry_out <= chunk_sum[CHUNK_WIDTH];
            overflow  <= msb_cin ^ chunk_sum[CHUNK_WIDTH];
            zero      <= (res_next == '0);
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
